// File: rtl/timer_apb_pkg.sv
// Shared definitions for the timer APB master: bus widths, wait counter
// width and the controller state encoding.
package timer_apb_pkg;

  localparam int APB_AW = 12;
  localparam int APB_DW = 32;
  localparam int CNT_W  = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_wait_cnt.sv
// Wait-state counter for the APB ACCESS phase. It clears when a new
// transfer is accepted and counts cycles in which the slave is not ready.
// It saturates at its maximum value instead of wrapping.
module apb_wait_cnt
  import timer_apb_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LP_MAX = '1;

  logic [CNT_W-1:0] r_count;

  // Clear has priority over increment; stop at the maximum value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != LP_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/timer_apb_master.sv
// Single-outstanding APB master for the timer block. It takes one command,
// runs SETUP/ACCESS on the APB side, waits up to TIMEOUT ACCESS cycles for
// tim_pready and returns the read data or a timeout flag on the response side.
// Every output is a register or a decode of the state register.
module timer_apb_master
  import timer_apb_pkg::*;
#(
  parameter int TIMEOUT = 16
)(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APB_AW-1:0] cmd_addr,
  input  logic [APB_DW-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              tim_psel,
  output logic              tim_penable,
  output logic              tim_pwrite,
  output logic [APB_AW-1:0] tim_paddr,
  output logic [APB_DW-1:0] tim_wdata,
  input  logic [APB_DW-1:0] tim_rdata,
  input  logic              tim_pready
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_pwrite;
  logic [APB_AW-1:0] r_paddr;
  logic [APB_DW-1:0] r_wdata;
  logic [APB_DW-1:0] r_rdata;
  logic              r_timeout;

  logic              w_accept;
  logic              w_done;
  logic              w_expire;
  logic              w_inc;
  logic [CNT_W-1:0]  w_count;

  // A ready slave wins over an expiring counter in the same cycle.
  assign w_accept = (r_state == ST_IDLE) && cmd_valid;
  assign w_done   = (r_state == ST_ACCESS) && tim_pready;
  assign w_inc    = (r_state == ST_ACCESS) && !tim_pready;
  assign w_expire = w_inc && (w_count == LP_LAST);

  apb_wait_cnt u_wait_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (w_accept),
    .inc       (w_inc),
    .count     (w_count)
  );

  // Next-state decode for the transfer sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_done || w_expire) w_next = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the command on acceptance; it drives the bus unchanged until the next one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_wdata  <= cmd_wdata;
    end
  end

  // Capture the response when ACCESS ends, either by completion or by timeout.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else if (w_done) begin
      r_rdata   <= r_pwrite ? '0 : tim_rdata;
      r_timeout <= 1'b0;
    end else if (w_expire) begin
      r_rdata   <= '0;
      r_timeout <= 1'b1;
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign tim_psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign tim_penable = (r_state == ST_ACCESS);
  assign tim_pwrite  = r_pwrite;
  assign tim_paddr   = r_paddr;
  assign tim_wdata   = r_wdata;
  assign rsp_rdata   = r_rdata;
  assign rsp_timeout = r_timeout;

endmodule
